fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the RV32 core. Owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word together with its PC into the IF/ID pipeline register consumed by decode. Handles decode-stage stall, taken branch/jump redirect with flush, halt on fetch of an all-zero word, and a retired-fetch counter.

## Interface

- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals current PC, combinational from the PC register.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- redirect  in  1  taken branch/jump resolved by decode this cycle.
- redirect_pc  in  32  target byte address; bits [1:0] are forced to 0.
- id_valid  out  1  IF/ID holds a live instruction.
- id_instr  out  32  registered instruction word.
- id_pc  out  32  address id_instr was fetched from.
- id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
- halted  out  1  fetch stopped after a zero word was captured.
- misalign_err  out  1  sticky: a redirect target had bit [1] set.
- fetch_count  out  32  number of instructions delivered to IF/ID (id_valid rising into a new word).

## Operation

- State machine: RUN, HALT. Reset enters RUN.
- Reset (rst_n low, asynchronous): pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, halted=0, misalign_err=0, fetch_count=0.
- RUN, per cycle, priority redirect > stall > advance:
  - redirect=1 (regardless of stall): pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0 (flush wrong-path word); id_instr/id_pc/id_pc_plus4 hold; misalign_err <= misalign_err | redirect_pc[1]; no halt check.
  - stall=1, redirect=0: pc and all id_* hold; fetch_count holds.
  - advance with imem_rdata != 0: id_instr <= imem_rdata, id_pc <= pc, id_pc_plus4 <= pc+4, id_valid <= 1, pc <= pc+4, fetch_count <= fetch_count+1.
  - advance with imem_rdata == 0: go to HALT; id_valid <= 0; pc holds; halted <= 1; fetch_count holds.
- HALT: terminal until reset. pc, id_*, fetch_count hold; id_valid=0; halted=1; redirect and stall ignored; misalign_err holds.
- Arithmetic: pc+4 and id_pc_plus4 wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). fetch_count wraps modulo 2^32.
- redirect_pc bit [0] is dropped silently; bit [1] flags misalign_err but fetch still proceeds at the word-aligned target.

## Timing

- imem_addr is valid the cycle pc is; memory is combinational, so fetch latency is 1 cycle: word at pc appears on id_instr after the next rising edge.
- First edge after rst_n deasserts (no stall/redirect): id_valid=1, id_pc=RESET_PC, pc=RESET_PC+4.
- Redirect penalty: 1 bubble (id_valid=0 for one cycle), target word in IF/ID on the second edge after redirect.
- redirect is sampled from decode of the current id_* word; a branch in IF/ID that redirects in the same cycle a zero word is presented prevents HALT.
- Reset asserted mid-operation (including HALT or during stall): all outputs return to reset values immediately, without waiting for clk.

## Test plan

- Reset/sequential fetch: memory 0x0:00700093, 0x4:00300193, 0x8:fff00113; release reset, no stall -> id_instr 00700093/00300193/fff00113 with id_pc 0/4/8 on edges 1-3, fetch_count=3.
- Stall: assert stall 2 cycles after edge 1 -> id_instr stays 00700093, id_pc 0, imem_addr stays 4, fetch_count stays 1; release -> 00300193 next edge.
- Redirect with flush: redirect=1, redirect_pc=0x10 while stall=1 -> next edge id_valid=0, imem_addr=0x10; following edge id_pc=0x10, id_valid=1.
- Misaligned target: redirect_pc=0x0000_0016 -> imem_addr=0x14, misalign_err=1 and stays 1 through later redirects until reset.
- Halt: program ends at 0x18, word at 0x1C is 0 -> after capture edge halted=1, id_valid=0, imem_addr holds 0x1C, redirect to 0x0 ignored; rst_n pulse low -> halted=0, imem_addr=0.
- Wrap: RESET_PC=32'hFFFF_FFFC, nonzero word there -> id_pc_plus4=0, imem_addr=0 after first edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads combinational instruction memory and
// fills the IF/ID register. Handles stall, redirect with flush, halt on zero word.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    // Bit 0 is dropped silently; bit 1 is still reported through misalign_err.
    assign target   = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    pc_d       = target;
                    id_valid_d = 1'b0;
                    misalign_d = misalign_q | redirect_pc[1];
                end else if (!stall) begin
                    if (imem_rdata != 32'd0) begin
                        id_instr_d    = imem_rdata;
                        id_pc_d       = pc_q;
                        id_pc_plus4_d = pc_plus4;
                        id_valid_d    = 1'b1;
                        pc_d          = pc_plus4;
                        fetch_count_d = fetch_count_q + 32'd1;
                    end else begin
                        state_d    = StHalt;
                        id_valid_d = 1'b0;
                    end
                end
            end
            StHalt: begin
                id_valid_d = 1'b0;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign id_valid     = id_valid_q;
    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_pc_plus4  = id_pc_plus4_q;
    assign halted       = (state_q == StHalt);
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule
